// File: rtl/score_pkg.sv
// Shared widths, defaults and FSM state type for the score display path.
package score_pkg;

  localparam int unsigned SCORE_W       = 17;
  localparam int unsigned NUM_DIGITS    = 5;
  localparam int unsigned BCD_W         = 4;
  localparam int unsigned DIGITS_W      = NUM_DIGITS * BCD_W;
  localparam int unsigned SCORE_MAX_DEF = 99999;

  typedef enum logic [1:0] {IDLE, CONV, PUB} state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle over SCORE_W cycles.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SCORE_W-1:0]  bin,
  output logic                done,
  output logic [DIGITS_W-1:0] bcd
);

  localparam int unsigned SH_W     = DIGITS_W + SCORE_W;
  localparam logic [4:0]  CNT_LAST = 5'(SCORE_W - 1);

  logic [SH_W-1:0] sh_q, sh_adj, sh_step;
  logic [4:0]      cnt_q;
  logic            run_q;

  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (sh_q[SCORE_W + i*BCD_W +: BCD_W] >= 4'd5) begin
        sh_adj[SCORE_W + i*BCD_W +: BCD_W] = sh_q[SCORE_W + i*BCD_W +: BCD_W] + 4'd3;
      end
    end
    sh_step = {sh_adj[SH_W-2:0], 1'b0};
  end

  // Result is presented combinationally on the final step so the caller can
  // register it on the same edge the converter finishes.
  assign done = run_q && (cnt_q == CNT_LAST);
  assign bcd  = sh_step[SH_W-1 -: DIGITS_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= {{DIGITS_W{1'b0}}, bin};
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_step;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == CNT_LAST) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Score register with round-robin add arbitration, saturation, and sequenced BCD publishing.
module score_sequencer
  import score_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADD_W     = 8,
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ADD_W-1:0] pts,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SCORE_W-1:0]       score,
  output logic [DIGITS_W-1:0]      digits,
  output logic [NUM_DIGITS-1:0]    blank,
  output logic                     digits_valid,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = SCORE_W + 1;
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  state_e                state_q;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [DIGITS_W-1:0]   digits_q;
  logic [NUM_DIGITS-1:0] blank_q, blank_calc;
  logic                  valid_q, clr_pend_q;
  logic [IDX_W-1:0]      rr_q;

  logic                  hi_hit, lo_hit, gnt_any, serve_clr, serve_add, conv_done, zero_above;
  logic [IDX_W-1:0]      hi_idx, lo_idx, gnt_idx;
  logic [ADD_W-1:0]      sel_pts;
  logic [SUM_W-1:0]      sum;
  logic [DIGITS_W-1:0]   bcd;

  // Two passes: lowest requester above rr_q, else wrap to lowest at or below it.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > rr_q)) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (req[i] && (IDX_W'(i) <= rr_q)) begin
        lo_hit = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
    gnt_any = hi_hit || lo_hit;
    gnt_idx = hi_hit ? hi_idx : lo_idx;
  end

  assign serve_clr = (state_q == IDLE) && (clr || clr_pend_q);
  assign serve_add = (state_q == IDLE) && !(clr || clr_pend_q) && gnt_any;

  assign sel_pts = pts[gnt_idx*ADD_W +: ADD_W];
  assign sum     = {1'b0, score_q} + SUM_W'(sel_pts);

  always_comb begin
    score_d = score_q;
    if (serve_clr) begin
      score_d = '0;
    end else if (serve_add) begin
      score_d = (sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      gnt[i] = serve_add && (gnt_idx == IDX_W'(i));
    end
  end

  always_comb begin
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_above    = zero_above && (bcd[i*BCD_W +: BCD_W] == '0);
      blank_calc[i] = zero_above;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (serve_clr || serve_add),
    .bin   (score_d),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      score_q    <= '0;
      digits_q   <= '0;
      blank_q    <= BLANK_RST;
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      valid_q <= 1'b0;
      if (serve_clr)  clr_pend_q <= 1'b0;
      else if (clr)   clr_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (serve_clr || serve_add) begin
            score_q <= score_d;
            state_q <= CONV;
          end
          if (serve_add) rr_q <= gnt_idx;
        end
        CONV: begin
          if (conv_done) begin
            digits_q <= bcd;
            blank_q  <= blank_calc;
            valid_q  <= 1'b1;
            state_q  <= PUB;
          end
        end
        PUB:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score        = score_q;
  assign digits       = digits_q;
  assign blank        = blank_q;
  assign digits_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: arbitration, saturation, clear, latency and reset abort.
module tb_score_sequencer;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [1:0]  req;
  logic [15:0] pts;
  logic [1:0]  gnt;
  logic [16:0] score;
  logic [19:0] digits;
  logic [4:0]  blank;
  logic        digits_valid, busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  score_sequencer #(.NUM_REQ(2), .ADD_W(8), .SCORE_MAX(99999)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .req          (req),
    .pts          (pts),
    .gnt          (gnt),
    .score        (score),
    .digits       (digits),
    .blank        (blank),
    .digits_valid (digits_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise req[idx] and wait (bounded) for its grant; returns in the grant cycle.
  task automatic issue(input int idx, input logic [7:0] p, output int t_gnt, output bit ok);
    pts[idx*8 +: 8] = p;
    req[idx] = 1'b1;
    ok = 1'b0;
    t_gnt = -1;
    for (int k = 0; k < 60 && !ok; k++) begin
      #1;
      if (gnt[idx]) begin
        ok = 1'b1;
        t_gnt = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic wait_valid(input int lim, output int t_v, output bit ok);
    ok = 1'b0;
    t_v = -1;
    for (int k = 0; k < lim && !ok; k++) begin
      step();
      if (digits_valid) begin
        ok = 1'b1;
        t_v = cyc;
      end
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    rst = 1'b1; clr = 1'b0; req = '0; pts = '0;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (digits_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_valid: got %b want 0", seen); end
    n_tests++; if (score !== 17'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_tests++; if (digits !== 20'h00000) begin n_fail++; $display("FAIL reset_digits: got %h want 00000", digits); end
    n_tests++; if (blank !== 5'b11110) begin n_fail++; $display("FAIL reset_blank: got %b want 11110", blank); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_single_add();
    int t, tv;
    bit ok;
    issue(0, 8'd123, t, ok);
    n_tests++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL add_gnt: got %b want 01", gnt); end
    step();
    req = '0;
    n_tests++; if (score !== 17'd123) begin n_fail++; $display("FAIL add_score: got %0d want 123", score); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || (tv - t) != 18) begin n_fail++; $display("FAIL add_latency: got %0d want 18", tv - t); end
    n_tests++; if (digits !== 20'h00123) begin n_fail++; $display("FAIL add_digits: got %h want 00123", digits); end
    n_tests++; if (blank !== 5'b11000) begin n_fail++; $display("FAIL add_blank: got %b want 11000", blank); end
    step();
    n_tests++; if (digits_valid !== 1'b0) begin n_fail++; $display("FAIL add_strobe_len: got %b want 0", digits_valid); end
  endtask

  task automatic test_saturate();
    int t, tv, rem, p;
    bit ok1, ok2, bulk_ok;
    rem = 99950 - 123;
    bulk_ok = 1'b1;
    while (rem > 0) begin
      p = (rem > 255) ? 255 : rem;
      issue(0, 8'(p), t, ok1);
      step();
      req = '0;
      wait_valid(30, tv, ok2);
      if (!ok1 || !ok2) bulk_ok = 1'b0;
      rem -= p;
    end
    n_tests++; if (bulk_ok !== 1'b1) begin n_fail++; $display("FAIL fill_handshake: got %b want 1", bulk_ok); end
    n_tests++; if (score !== 17'd99950) begin n_fail++; $display("FAIL fill_score: got %0d want 99950", score); end
    n_tests++; if (digits !== 20'h99950) begin n_fail++; $display("FAIL fill_digits: got %h want 99950", digits); end
    n_tests++; if (blank !== 5'b00000) begin n_fail++; $display("FAIL fill_blank: got %b want 00000", blank); end
    issue(1, 8'd200, t, ok1);
    n_tests++; if (!ok1 || gnt !== 2'b10) begin n_fail++; $display("FAIL sat_gnt: got %b want 10", gnt); end
    step();
    req = '0;
    n_tests++; if (score !== 17'd99999) begin n_fail++; $display("FAIL sat_score: got %0d want 99999", score); end
    wait_valid(30, tv, ok2);
    n_tests++; if (!ok2 || digits !== 20'h99999) begin n_fail++; $display("FAIL sat_digits: got %h want 99999", digits); end
    n_tests++; if (blank !== 5'b00000) begin n_fail++; $display("FAIL sat_blank: got %b want 00000", blank); end
    issue(1, 8'd7, t, ok1);
    step();
    req = '0;
    n_tests++; if (!ok1 || score !== 17'd99999) begin n_fail++; $display("FAIL sat_hold: got %0d want 99999", score); end
    wait_valid(30, tv, ok2);
    n_tests++; if (!ok2 || digits !== 20'h99999) begin n_fail++; $display("FAIL sat_hold_digits: got %h want 99999", digits); end
  endtask

  task automatic test_clear_idle();
    int t, tv;
    bit ok;
    step();
    clr = 1'b1;
    t = cyc;
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL clr_gnt: got %b want 00", gnt); end
    step();
    clr = 1'b0;
    n_tests++; if (score !== 17'd0) begin n_fail++; $display("FAIL clr_score: got %0d want 0", score); end
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || (tv - t) != 18) begin n_fail++; $display("FAIL clr_latency: got %0d want 18", tv - t); end
    n_tests++; if (digits !== 20'h00000) begin n_fail++; $display("FAIL clr_digits: got %h want 00000", digits); end
    n_tests++; if (blank !== 5'b11110) begin n_fail++; $display("FAIL clr_blank: got %b want 11110", blank); end
  endtask

  task automatic test_back_to_back();
    int tg[3];
    logic [1:0] gv[3];
    logic [1:0] exp_g[3];
    int tv;
    bit ok, found;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    pts = {8'd20, 8'd10};
    req = 2'b11;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      tg[g] = -1;
      gv[g] = 2'b00;
      for (int k = 0; k < 40 && !found; k++) begin
        #1;
        if (gnt !== 2'b00) begin
          found = 1'b1;
          tg[g] = cyc;
          gv[g] = gnt;
        end
        step();
      end
      n_tests++; if (gv[g] !== exp_g[g]) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", g, gv[g], exp_g[g]); end
    end
    n_tests++; if (tg[1] - tg[0] != 19) begin n_fail++; $display("FAIL rr_gap0: got %0d want 19", tg[1] - tg[0]); end
    n_tests++; if (tg[2] - tg[1] != 19) begin n_fail++; $display("FAIL rr_gap1: got %0d want 19", tg[2] - tg[1]); end
    req = '0;
    n_tests++; if (score !== 17'd40) begin n_fail++; $display("FAIL rr_score: got %0d want 40", score); end
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || digits !== 20'h00040) begin n_fail++; $display("FAIL rr_digits: got %h want 00040", digits); end
  endtask

  task automatic test_clr_during_conv();
    int t, tv;
    bit ok;
    step();
    issue(0, 8'd5, t, ok);
    n_tests++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL cc_gnt: got %b want 01", gnt); end
    step();
    req = '0;
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    pts[15:8] = 8'd9;
    req[1] = 1'b1;
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || (tv - t) != 18) begin n_fail++; $display("FAIL cc_latency: got %0d want 18", tv - t); end
    n_tests++; if (digits !== 20'h00045) begin n_fail++; $display("FAIL cc_digits: got %h want 00045", digits); end
    n_tests++; if (blank !== 5'b11100) begin n_fail++; $display("FAIL cc_blank: got %b want 11100", blank); end
    step();
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL cc_no_gnt: got %b want 00", gnt); end
    step();
    n_tests++; if (score !== 17'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL cc_cleared: got %0d/%b want 0/1", score, busy); end
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || (tv - t) != 37) begin n_fail++; $display("FAIL cc_clr_latency: got %0d want 37", tv - t); end
    n_tests++; if (digits !== 20'h00000 || blank !== 5'b11110) begin n_fail++; $display("FAIL cc_clr_digits: got %h/%b want 00000/11110", digits, blank); end
    step();
    #1;
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL cc_next_gnt: got %b want 10", gnt); end
    step();
    req = '0;
    n_tests++; if (score !== 17'd9) begin n_fail++; $display("FAIL cc_next_score: got %0d want 9", score); end
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || digits !== 20'h00009) begin n_fail++; $display("FAIL cc_next_digits: got %h want 00009", digits); end
  endtask

  task automatic test_reset_mid();
    int t, tv;
    bit ok, seen;
    step();
    issue(0, 8'd50, t, ok);
    n_tests++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL rm_gnt: got %b want 01", gnt); end
    step();
    req = '0;
    repeat (8) step();
    rst = 1'b1;
    #1;
    n_tests++; if (score !== 17'd0 || digits !== 20'h00000) begin n_fail++; $display("FAIL rm_regs: got %0d/%h want 0/00000", score, digits); end
    n_tests++; if (blank !== 5'b11110) begin n_fail++; $display("FAIL rm_blank: got %b want 11110", blank); end
    n_tests++; if (busy !== 1'b0 || digits_valid !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL rm_ctrl: got %b%b%b want 0000", busy, digits_valid, gnt); end
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (digits_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_no_strobe: got %b want 0", seen); end
    issue(0, 8'd7, t, ok);
    n_tests++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL rm_regnt: got %b want 01", gnt); end
    step();
    req = '0;
    wait_valid(30, tv, ok);
    n_tests++; if (!ok || score !== 17'd7 || digits !== 20'h00007) begin n_fail++; $display("FAIL rm_digits: got %0d/%h want 7/00007", score, digits); end
    n_tests++; if (blank !== 5'b11110) begin n_fail++; $display("FAIL rm_blank2: got %b want 11110", blank); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_saturate();
    test_clear_idle();
    test_back_to_back();
    test_clr_during_conv();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
